// File: rtl/demux_pkg.sv
// Shared route-code constants and slot state encoding for the 1:2 stream demultiplexer.
package demux_pkg;

   localparam int unsigned SEL_W = 2;
   localparam int unsigned CNT_W = 8;

   localparam logic [SEL_W-1:0] SEL_A    = 2'b00;
   localparam logic [SEL_W-1:0] SEL_B    = 2'b01;
   localparam logic [SEL_W-1:0] SEL_BOTH = 2'b10;
   localparam logic [SEL_W-1:0] SEL_DROP = 2'b11;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } slot_state_t;

   // Route code steers a beat into output A (either alone or as part of a broadcast).
   function automatic logic sel_hits_a(input logic [SEL_W-1:0] sel);
      return (sel == SEL_A) || (sel == SEL_BOTH);
   endfunction

   function automatic logic sel_hits_b(input logic [SEL_W-1:0] sel);
      return (sel == SEL_B) || (sel == SEL_BOTH);
   endfunction

endpackage

// File: rtl/demux_slot.sv
// One-entry output holding register: EMPTY/FULL with same-edge drain and refill.
module demux_slot
   import demux_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [WIDTH-1:0] data_in,
   input  logic             ready,
   output logic             valid,
   output logic [WIDTH-1:0] data_out,
   output logic             can_take_c,
   output logic             fire_c
);

   slot_state_t      state_q, state_d;
   logic [WIDTH-1:0] data_q, data_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_EMPTY;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
      end
   end

   // A load always wins over a drain so the new payload replaces the departing one.
   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      case (state_q)
         ST_EMPTY: begin
            if (load) begin
               state_d = ST_FULL;
               data_d  = data_in;
            end
         end
         ST_FULL: begin
            if (load) begin
               data_d = data_in;
            end else if (ready) begin
               state_d = ST_EMPTY;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   assign valid      = (state_q == ST_FULL);
   assign data_out   = data_q;
   assign can_take_c = (state_q == ST_EMPTY) || ready;
   assign fire_c     = (state_q == ST_FULL) && ready;

endmodule

// File: rtl/demux1_2.sv
// Registered 1-to-2 stream demultiplexer with per-output holding slots.
// Optional delivered-beat counters CntA/CntB are built when DEMUX1_2_CNT_EN is defined.
module demux1_2
   import demux_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] InData,
   input  logic [SEL_W-1:0] InSel,
   input  logic             InValid,
   output logic             InReady,
   output logic [WIDTH-1:0] OutA,
   output logic             OutAValid,
   input  logic             OutAReady,
   output logic [WIDTH-1:0] OutB,
   output logic             OutBValid,
   input  logic             OutBReady
`ifdef DEMUX1_2_CNT_EN
   ,
   output logic [CNT_W-1:0] CntA,
   output logic [CNT_W-1:0] CntB
`endif
);

   logic can_take_a, can_take_b;
   logic fire_a, fire_b;
   logic accept;
   logic load_a, load_b;

   // Broadcast needs both slots free so it never loads only one side.
   always_comb begin
      InReady = 1'b1;
      case (InSel)
         SEL_A:    InReady = can_take_a;
         SEL_B:    InReady = can_take_b;
         SEL_BOTH: InReady = can_take_a && can_take_b;
         SEL_DROP: InReady = 1'b1;
         default:  InReady = 1'b1;
      endcase
   end

   assign accept = InValid && InReady;
   assign load_a = accept && sel_hits_a(InSel);
   assign load_b = accept && sel_hits_b(InSel);

   demux_slot #(.WIDTH(WIDTH)) u_slot_a (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load_a),
      .data_in    (InData),
      .ready      (OutAReady),
      .valid      (OutAValid),
      .data_out   (OutA),
      .can_take_c (can_take_a),
      .fire_c     (fire_a)
   );

   demux_slot #(.WIDTH(WIDTH)) u_slot_b (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load_b),
      .data_in    (InData),
      .ready      (OutBReady),
      .valid      (OutBValid),
      .data_out   (OutB),
      .can_take_c (can_take_b),
      .fire_c     (fire_b)
   );

`ifdef DEMUX1_2_CNT_EN
   logic [CNT_W-1:0] cnt_a_q, cnt_b_q;

   // Delivered-beat counters wrap naturally at 8 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_a_q <= '0;
         cnt_b_q <= '0;
      end else begin
         if (fire_a) cnt_a_q <= cnt_a_q + CNT_W'(1);
         if (fire_b) cnt_b_q <= cnt_b_q + CNT_W'(1);
      end
   end

   assign CntA = cnt_a_q;
   assign CntB = cnt_b_q;
`else
   // Handshake strobes only feed the counters; keep them tied off otherwise.
   logic unused_fire;
   assign unused_fire = fire_a ^ fire_b;
`endif

endmodule

// File: tb/tb_demux1_2.sv
// Self-checking bench for demux1_2: directed scenarios plus randomized traffic
// checked against a queue-based reference model (DEMUX1_2_CNT_EN adds counter checks).
module tb_demux1_2;
   import demux_pkg::*;

   localparam int unsigned WIDTH = 16;

   logic             clk;
   logic             rst_n;
   logic [WIDTH-1:0] InData;
   logic [1:0]       InSel;
   logic             InValid;
   logic             InReady;
   logic [WIDTH-1:0] OutA, OutB;
   logic             OutAValid, OutBValid;
   logic             OutAReady, OutBReady;
`ifdef DEMUX1_2_CNT_EN
   logic [7:0]       CntA, CntB;
`endif

   demux1_2 #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .InData    (InData),
      .InSel     (InSel),
      .InValid   (InValid),
      .InReady   (InReady),
      .OutA      (OutA),
      .OutAValid (OutAValid),
      .OutAReady (OutAReady),
      .OutB      (OutB),
      .OutBValid (OutBValid),
      .OutBReady (OutBReady)
`ifdef DEMUX1_2_CNT_EN
      ,
      .CntA      (CntA),
      .CntB      (CntB)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;
   int unsigned ready_drops = 0;

   // Reference model: each output is a queue of beats awaiting its consumer.
   logic [WIDTH-1:0] qa[$];
   logic [WIDTH-1:0] qb[$];
   int unsigned      cnt_a = 0;
   int unsigned      cnt_b = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
   endtask

   // One cycle: apply inputs, compare against the model, clock, then advance the model.
   task automatic step(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] d,
                       input logic ra, input logic rb);
      logic room_a, room_b, exp_rdy, acc;
      InValid = v; InSel = s; InData = d; OutAReady = ra; OutBReady = rb;
      #1;
      check("a_valid", 32'(OutAValid), 32'(qa.size() != 0));
      check("b_valid", 32'(OutBValid), 32'(qb.size() != 0));
      if (qa.size() != 0) check("a_data", 32'(OutA), 32'(qa[0]));
      if (qb.size() != 0) check("b_data", 32'(OutB), 32'(qb[0]));
      room_a = (qa.size() == 0) || ra;
      room_b = (qb.size() == 0) || rb;
      case (s)
         2'd0:    exp_rdy = room_a;
         2'd1:    exp_rdy = room_b;
         2'd2:    exp_rdy = room_a && room_b;
         default: exp_rdy = 1'b1;
      endcase
      check("in_ready", 32'(InReady), 32'(exp_rdy));
`ifdef DEMUX1_2_CNT_EN
      check("cnt_a", 32'(CntA), 32'(cnt_a % 256));
      check("cnt_b", 32'(CntB), 32'(cnt_b % 256));
`endif
      if (v && !InReady) ready_drops++;
      acc = v && exp_rdy;
      @(posedge clk);
      if (qa.size() != 0 && ra) begin void'(qa.pop_front()); cnt_a++; end
      if (qb.size() != 0 && rb) begin void'(qb.pop_front()); cnt_b++; end
      if (acc && (s == 2'd0 || s == 2'd2)) qa.push_back(d);
      if (acc && (s == 2'd1 || s == 2'd2)) qb.push_back(d);
      #1;
   endtask

   // Async reset in the middle of a cycle, then release and probe InReady for every code.
   task automatic mid_reset();
      #2 rst_n = 1'b0;
      #1;
      check("rst_a_valid", 32'(OutAValid), 32'd0);
      check("rst_b_valid", 32'(OutBValid), 32'd0);
      check("rst_a_data", 32'(OutA), 32'd0);
      check("rst_b_data", 32'(OutB), 32'd0);
`ifdef DEMUX1_2_CNT_EN
      check("rst_cnt_a", 32'(CntA), 32'd0);
      check("rst_cnt_b", 32'(CntB), 32'd0);
`endif
      qa.delete(); qb.delete(); cnt_a = 0; cnt_b = 0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      InValid = 1'b0; OutAReady = 1'b0; OutBReady = 1'b0;
      for (int c = 0; c < 4; c++) begin
         InSel = 2'(c);
         #1 check("rst_in_ready", 32'(InReady), 32'd1);
      end
   endtask

   initial begin
      int unsigned drops0;
      rst_n = 1'b0; InValid = 1'b0; InSel = '0; InData = '0;
      OutAReady = 1'b0; OutBReady = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("init_a_valid", 32'(OutAValid), 32'd0);
      check("init_b_valid", 32'(OutBValid), 32'd0);
      check("init_a_data", 32'(OutA), 32'd0);
      rst_n = 1'b1;

      // Routing: A, B, drop with both consumers ready.
      step(1'b1, SEL_A, 16'h1111, 1'b1, 1'b1);
      check("route_a", 32'(OutA), 32'h1111);
      step(1'b1, SEL_B, 16'h2222, 1'b1, 1'b1);
      check("route_b", 32'(OutB), 32'h2222);
      check("route_a_gone", 32'(OutAValid), 32'd0);
      step(1'b1, SEL_DROP, 16'h3333, 1'b1, 1'b1);
      check("drop_a", 32'(OutAValid), 32'd0);
      check("drop_b", 32'(OutBValid), 32'd0);

      // Stall on A while B keeps flowing.
      step(1'b1, SEL_A, 16'hAAAA, 1'b0, 1'b1);
      step(1'b1, SEL_A, 16'hBBBB, 1'b0, 1'b1);
      check("stall_hold", 32'(OutA), 32'hAAAA);
      step(1'b1, SEL_B, 16'h5555, 1'b0, 1'b1);
      check("stall_b_flow", 32'(OutB), 32'h5555);
      check("stall_hold2", 32'(OutA), 32'hAAAA);
      step(1'b1, SEL_A, 16'hBBBB, 1'b1, 1'b1);
      check("stall_refill", 32'(OutA), 32'hBBBB);
      step(1'b0, SEL_A, 16'h0000, 1'b1, 1'b1);

      // Broadcast blocked by a full, stalled B; A must not load alone.
      step(1'b1, SEL_B, 16'h1234, 1'b1, 1'b0);
      step(1'b1, SEL_BOTH, 16'hC0DE, 1'b1, 1'b0);
      check("bcast_no_a", 32'(OutAValid), 32'd0);
      step(1'b1, SEL_BOTH, 16'hC0DE, 1'b1, 1'b1);
      check("bcast_a", 32'(OutA), 32'hC0DE);
      check("bcast_b", 32'(OutB), 32'hC0DE);
      step(1'b0, SEL_A, 16'h0000, 1'b1, 1'b1);

      // Back-to-back alternating traffic must never stall.
      drops0 = ready_drops;
      for (int i = 0; i < 8; i++)
         step(1'b1, 2'(i % 2), 16'(16'h0100 + i), 1'b1, 1'b1);
      check("b2b_no_stall", ready_drops - drops0, 32'd0);
      step(1'b0, SEL_A, 16'h0000, 1'b1, 1'b1);

      // Reset with both slots full.
      step(1'b1, SEL_A, 16'hDEAD, 1'b0, 1'b0);
      step(1'b1, SEL_B, 16'hBEEF, 1'b0, 1'b0);
      check("pre_rst_a", 32'(OutAValid), 32'd1);
      check("pre_rst_b", 32'(OutBValid), 32'd1);
      mid_reset();

      // Randomized traffic with mostly-ready consumers.
      for (int i = 0; i < 400; i++)
         step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), 16'($urandom),
              1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));

`ifdef DEMUX1_2_CNT_EN
      // 257 deliveries to A wrap the counter to 1.
      step(1'b0, SEL_A, 16'h0000, 1'b1, 1'b1);
      mid_reset();
      for (int i = 0; i < 257; i++)
         step(1'b1, SEL_A, 16'(i), 1'b1, 1'b1);
      step(1'b0, SEL_A, 16'h0000, 1'b1, 1'b1);
      check("cnt_wrap_a", 32'(CntA), 32'd1);
      check("cnt_wrap_b", 32'(CntB), 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   // Bound the run in case the bench ever stalls.
   initial begin
      #500000;
      $display("FAIL timeout: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
      $fatal(1);
   end

endmodule

// File: doc/demux1_2.md
# demux1_2

Registered 1-to-2 stream demultiplexer: the steering end of the datapath that the 2:1 mux merges. One valid/ready input stream is routed per beat to output A, output B, both (broadcast), or nowhere (drop), selected by a sideband code sampled with the data. Each output has a one-entry holding register, so back-pressure on one output never corrupts the other output's data. It sits between a single producer and two independent consumers.

## Interface
- WIDTH, default 16, data width in bits.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- InData  input  WIDTH  input beat payload.
- InSel  input  2  route code, qualified by InValid: 00=A, 01=B, 10=both, 11=drop.
- InValid  input  1  producer presents a beat.
- InReady  output  1  beat accepted this cycle when InValid&InReady.
- OutA  output  WIDTH  output A payload.
- OutAValid  output  1  output A holds a beat.
- OutAReady  input  1  consumer A takes the beat when OutAValid&OutAReady.
- OutB, OutBValid, OutBReady: as for A.
- CntA, CntB  output  8  beats delivered per output; present only with DEMUX1_2_CNT_EN.

## Operation
- Each output slot has 2 states: EMPTY (Valid=0), FULL (Valid=1, payload held stable).
- Slot "can take" = EMPTY, or FULL and its Ready=1 this cycle (drain and refill same edge).
- InReady, combinational from slot state, OutxReady and InSel:
  - 00: canTakeA. 01: canTakeB. 10: canTakeA AND canTakeB. 11: 1.
- On accept: targeted slot(s) load InData and go FULL; code 11 discards the beat with no output effect.
- Broadcast is all-or-nothing: never loads only one slot.
- Slot FULL, Ready=1, no new load -> EMPTY. Slot FULL, Ready=0 -> unchanged, payload stable.
- InSel and InData are don't-care while InValid=0; InReady may toggle regardless of InValid.
- No combinational path from InValid/InData to any output; OutxReady -> InReady is combinational (allowed).

## Timing
- Reset (async assert, sync-safe deassert by the environment): both slots EMPTY, OutAValid=OutBValid=0, OutA=OutB=0, CntA=CntB=0. InReady after reset is 1 for every code.
- Latency: beat accepted at edge N is presented at output from after edge N, i.e. visible cycle N+1.
- Throughput: 1 beat/cycle per output while its consumer holds Ready=1; alternating A/B codes sustain 1 beat/cycle total.
- Simultaneous drain and refill of the same slot: new payload wins, Valid stays 1, count increments for the drained beat.
- Broadcast with A ready and B stalled: InReady=0, A still drains its old beat normally.
- Reset asserted mid-transfer: held beats are lost, slots EMPTY immediately, counters cleared.

## Configuration
- DEMUX1_2_CNT_EN defined: CntA/CntB ports exist; each increments by 1 on every OutxValid&OutxReady handshake, wraps 255->0, cleared by reset.
- Undefined: ports and counter logic absent; all other behaviour identical.

## Structure
- Shared package demux_pkg: route-code constants SEL_A=2'b00, SEL_B=2'b01, SEL_BOTH=2'b10, SEL_DROP=2'b11; slot state encoding ST_EMPTY/ST_FULL.
- One sub-module, demux_slot (parameter WIDTH): load, data in, Ready in; Valid, data out, can-take out, fire (handshake) out. Instantiated twice; top holds InReady/load decode and optional counters.

## Test plan
- Reset: rst_n low mid-run with both slots FULL -> OutAValid=OutBValid=0, OutA=OutB=0 immediately; after release, InReady=1.
- Routing: 0x1111/00, 0x2222/01, 0x3333/11 with both Ready=1 -> A gets 0x1111 cycle 1, B gets 0x2222 cycle 2, 0x3333 appears nowhere.
- Stall: OutAReady=0, send 0xAAAA/00 then 0xBBBB/00 -> second beat InReady=0 held; OutA stable 0xAAAA; release Ready -> 0xBBBB next cycle; B traffic unaffected throughout.
- Broadcast: 0xC0DE/10 with OutBReady=0 and B FULL -> InReady=0, no load to A; B drains -> both outputs present 0xC0DE same cycle.
- Back-to-back: 8 beats alternating 00/01, both Ready=1 -> InReady never drops, each output sees 4 beats in order.
- Counters (DEMUX1_2_CNT_EN): 257 beats to A -> CntA=1, CntB=0.
